// File: rtl/systolic_pe_param_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
// Accumulator bounds are returned 64 bits wide; callers keep the low ACC_W bits.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} pe_state_t;

  // Pass-through latency of one PE, used by the array wrapper to skew operands.
  localparam int PE_LAT = 1;

  function automatic logic [63:0] acc_max(int acc_w, bit is_signed);
    return is_signed ? (64'd1 << (acc_w - 1)) - 64'd1 : (64'd1 << acc_w) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(int acc_w, bit is_signed);
    return is_signed ? ~((64'd1 << (acc_w - 1)) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/systolic_pe_param_if.sv
// Operand/result bundle of one PE; master drives operands and tile control.
interface systolic_pe_param_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int K_W    = 8
);
  logic              start;
  logic [K_W-1:0]    k_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              pass_valid;
  logic [DATA_W-1:0] pass_right;
  logic [DATA_W-1:0] pass_down;
  logic              busy;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              overflow;

  modport master (
    output start, k_len, in_valid, in_a, in_b,
    input  pass_valid, pass_right, pass_down, busy, result, result_valid, overflow
  );

  modport slave (
    input  start, k_len, in_valid, in_a, in_b,
    output pass_valid, pass_right, pass_down, busy, result, result_valid, overflow
  );
endinterface

// File: rtl/systolic_pe_param_datapath.sv
// Combinational multiply, extend and (optionally saturating) accumulate.
// clr substitutes zero for the accumulator so a tile can clear and add in one cycle.
module pe_mac_datapath
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              clr,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  localparam int PW = 2 * DATA_W;
  localparam logic [63:0] MAX64 = acc_max(ACC_W, SIGNED);
  localparam logic [63:0] MIN64 = acc_min(ACC_W, SIGNED);
  localparam logic [ACC_W-1:0] MAX_V = MAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MIN_V = MIN64[ACC_W-1:0];

  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] acc_eff;
  logic [ACC_W:0]   prod_x;
  logic [ACC_W:0]   acc_x;
  logic [ACC_W:0]   sum_x;
  logic             neg;

  assign acc_eff = clr ? '0 : acc_in;

  // One guard bit above ACC_W exposes both signed overflow and unsigned carry.
  if (SIGNED) begin : g_signed
    assign prod   = PW'($signed(a)) * PW'($signed(b));
    assign prod_x = {{(ACC_W + 1 - PW){prod[PW-1]}}, prod};
    assign acc_x  = {acc_eff[ACC_W-1], acc_eff};
    assign ovf    = sum_x[ACC_W] ^ sum_x[ACC_W-1];
    assign neg    = sum_x[ACC_W];
  end else begin : g_unsigned
    assign prod   = PW'(a) * PW'(b);
    assign prod_x = {{(ACC_W + 1 - PW){1'b0}}, prod};
    assign acc_x  = {1'b0, acc_eff};
    assign ovf    = sum_x[ACC_W];
    assign neg    = 1'b0;
  end

  assign sum_x = acc_x + prod_x;
  assign sum   = (ovf && SATURATE) ? (neg ? MIN_V : MAX_V) : sum_x[ACC_W-1:0];
endmodule

// File: rtl/systolic_pe_param.sv
// Output-stationary systolic MAC cell: forwards operands with 1-cycle latency and
// accumulates exactly k_len products per tile, pulsing result_valid on completion.
module systolic_pe_param
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int K_W      = 8,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  systolic_pe_param_if.slave pe
);
  pe_state_t         state_q, state_d;
  logic [K_W-1:0]    count_q, count_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              pass_valid_q;
  logic [DATA_W-1:0] pass_right_q, pass_down_q;
  logic              clr;
  logic [ACC_W-1:0]  mac_sum;
  logic              mac_ovf;
  logic              busy, result_valid;

  pe_mac_datapath #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED), .SATURATE(SATURATE)
  ) u_mac (
    .a(pe.in_a), .b(pe.in_b), .acc_in(result_q), .clr(clr),
    .sum(mac_sum), .ovf(mac_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start pre-empts every state, so abandoned tiles never reach DONE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    k_d      = k_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    clr      = 1'b0;
    if (pe.start) begin
      clr      = 1'b1;
      k_d      = pe.k_len;
      count_d  = '0;
      result_d = '0;
      ovf_d    = 1'b0;
      if (pe.k_len == '0) begin
        state_d = DONE;
      end else if (pe.in_valid) begin
        result_d = mac_sum;
        ovf_d    = mac_ovf;
        count_d  = K_W'(1);
        state_d  = (pe.k_len == K_W'(1)) ? DONE : ACCUM;
      end else begin
        state_d = ACCUM;
      end
    end else begin
      case (state_q)
        ACCUM: if (pe.in_valid) begin
          result_d = mac_sum;
          ovf_d    = ovf_q | mac_ovf;
          count_d  = count_q + K_W'(1);
          if (count_q + K_W'(1) == k_q) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state_q == ACCUM);
    result_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      k_q          <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      pass_valid_q <= 1'b0;
      pass_right_q <= '0;
      pass_down_q  <= '0;
    end else begin
      count_q      <= count_d;
      k_q          <= k_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      pass_valid_q <= pe.in_valid;
      if (pe.in_valid) begin
        pass_right_q <= pe.in_a;
        pass_down_q  <= pe.in_b;
      end
    end
  end

  assign pe.pass_valid   = pass_valid_q;
  assign pe.pass_right   = pass_right_q;
  assign pe.pass_down    = pass_down_q;
  assign pe.busy         = busy;
  assign pe.result       = result_q;
  assign pe.result_valid = result_valid;
  assign pe.overflow     = ovf_q;
endmodule

// File: tb/tb_systolic_pe_param.sv
// Four PE configurations driven by one stimulus stream, checked against an arithmetic tile model.
module tb_systolic_pe_param;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] k_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;

  always #5 clk = ~clk;

  systolic_pe_param_if #(.DATA_W(8), .ACC_W(24), .K_W(8)) if0 ();
  systolic_pe_param_if #(.DATA_W(8), .ACC_W(16), .K_W(8)) if1 ();
  systolic_pe_param_if #(.DATA_W(8), .ACC_W(16), .K_W(8)) if2 ();
  systolic_pe_param_if #(.DATA_W(8), .ACC_W(16), .K_W(8)) if3 ();

  assign if0.start = start; assign if0.k_len = k_len; assign if0.in_valid = in_valid;
  assign if0.in_a = in_a;   assign if0.in_b = in_b;
  assign if1.start = start; assign if1.k_len = k_len; assign if1.in_valid = in_valid;
  assign if1.in_a = in_a;   assign if1.in_b = in_b;
  assign if2.start = start; assign if2.k_len = k_len; assign if2.in_valid = in_valid;
  assign if2.in_a = in_a;   assign if2.in_b = in_b;
  assign if3.start = start; assign if3.k_len = k_len; assign if3.in_valid = in_valid;
  assign if3.in_a = in_a;   assign if3.in_b = in_b;

  systolic_pe_param #(.DATA_W(8), .ACC_W(24), .K_W(8), .SIGNED(1'b1), .SATURATE(1'b1))
    dut0 (.clk(clk), .rst(rst), .pe(if0.slave));
  systolic_pe_param #(.DATA_W(8), .ACC_W(16), .K_W(8), .SIGNED(1'b1), .SATURATE(1'b1))
    dut1 (.clk(clk), .rst(rst), .pe(if1.slave));
  systolic_pe_param #(.DATA_W(8), .ACC_W(16), .K_W(8), .SIGNED(1'b1), .SATURATE(1'b0))
    dut2 (.clk(clk), .rst(rst), .pe(if2.slave));
  systolic_pe_param #(.DATA_W(8), .ACC_W(16), .K_W(8), .SIGNED(1'b0), .SATURATE(1'b1))
    dut3 (.clk(clk), .rst(rst), .pe(if3.slave));

  logic [23:0] res_a [N];
  logic [7:0]  pr_a [N];
  logic [7:0]  pd_a [N];
  logic        pv_a [N];
  logic        busy_a [N];
  logic        rv_a [N];
  logic        ovf_a [N];

  assign res_a[0] = if0.result;       assign res_a[1] = 24'(if1.result);
  assign res_a[2] = 24'(if2.result);  assign res_a[3] = 24'(if3.result);
  assign pr_a[0] = if0.pass_right; assign pr_a[1] = if1.pass_right;
  assign pr_a[2] = if2.pass_right; assign pr_a[3] = if3.pass_right;
  assign pd_a[0] = if0.pass_down;  assign pd_a[1] = if1.pass_down;
  assign pd_a[2] = if2.pass_down;  assign pd_a[3] = if3.pass_down;
  assign pv_a[0] = if0.pass_valid; assign pv_a[1] = if1.pass_valid;
  assign pv_a[2] = if2.pass_valid; assign pv_a[3] = if3.pass_valid;
  assign busy_a[0] = if0.busy; assign busy_a[1] = if1.busy;
  assign busy_a[2] = if2.busy; assign busy_a[3] = if3.busy;
  assign rv_a[0] = if0.result_valid; assign rv_a[1] = if1.result_valid;
  assign rv_a[2] = if2.result_valid; assign rv_a[3] = if3.result_valid;
  assign ovf_a[0] = if0.overflow; assign ovf_a[1] = if1.overflow;
  assign ovf_a[2] = if2.overflow; assign ovf_a[3] = if3.overflow;

  // Configuration of each instance, as seen by the model.
  int accw [N] = '{24, 16, 16, 16};
  bit sgn  [N] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit sat  [N] = '{1'b1, 1'b1, 1'b0, 1'b1};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: numeric accumulator value plus tile bookkeeping per instance.
  longint m_res [N];
  bit     m_ovf [N];
  bit     m_busy [N];
  bit     m_rv [N];
  int     m_cnt [N];
  int     m_k [N];
  bit     m_pv;
  logic [7:0] m_pr, m_pd;
  bit     checking = 1'b0;

  function automatic longint mask_of(int i);
    return (longint'(1) << accw[i]) - 1;
  endfunction

  task automatic macc(int i, logic [7:0] a, logic [7:0] b);
    longint pa, pb, s, hi, lo, span;
    pa = longint'(a); pb = longint'(b);
    if (sgn[i] && a[7]) pa -= 256;
    if (sgn[i] && b[7]) pb -= 256;
    span = longint'(1) << accw[i];
    hi = sgn[i] ? (span / 2) - 1 : span - 1;
    lo = sgn[i] ? -(span / 2) : 0;
    s = m_res[i] + pa * pb;
    if (s > hi || s < lo) begin
      m_ovf[i] = 1'b1;
      if (sat[i]) s = (s > hi) ? hi : lo;
      else begin
        s = s & (span - 1);
        if (s > hi) s -= span;
      end
    end
    m_res[i] = s;
  endtask

  task automatic model_step(bit r, bit s, int k, bit v, logic [7:0] a, logic [7:0] b);
    if (r) begin
      m_pv = 0; m_pr = '0; m_pd = '0;
      for (int i = 0; i < N; i++) begin
        m_res[i] = 0; m_ovf[i] = 0; m_busy[i] = 0; m_rv[i] = 0; m_cnt[i] = 0; m_k[i] = 0;
      end
      return;
    end
    m_pv = v;
    if (v) begin m_pr = a; m_pd = b; end
    for (int i = 0; i < N; i++) begin
      if (s) begin
        m_k[i] = k; m_res[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
        if (k != 0 && v) begin macc(i, a, b); m_cnt[i] = 1; end
        m_rv[i] = (m_cnt[i] == k);
        m_busy[i] = !m_rv[i];
      end else if (m_busy[i]) begin
        if (v) begin
          macc(i, a, b);
          m_cnt[i]++;
          if (m_cnt[i] == m_k[i]) begin m_busy[i] = 0; m_rv[i] = 1; end
        end
      end else begin
        m_rv[i] = 0;
      end
    end
  endtask

  bit         c_r, c_s, c_v;
  logic [7:0] c_k, c_a, c_b;

  always @(posedge clk) begin
    c_r = rst; c_s = start; c_k = k_len; c_v = in_valid; c_a = in_a; c_b = in_b;
    model_step(c_r, c_s, int'(c_k), c_v, c_a, c_b);
    #1;
    if (c_r) checking = 1'b1;
    if (checking) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("d%0d.result", i), longint'(res_a[i]), m_res[i] & mask_of(i));
        chk($sformatf("d%0d.result_valid", i), longint'(rv_a[i]), longint'(m_rv[i]));
        chk($sformatf("d%0d.busy", i), longint'(busy_a[i]), longint'(m_busy[i]));
        chk($sformatf("d%0d.overflow", i), longint'(ovf_a[i]), longint'(m_ovf[i]));
        chk($sformatf("d%0d.pass_valid", i), longint'(pv_a[i]), longint'(m_pv));
        chk($sformatf("d%0d.pass_right", i), longint'(pr_a[i]), longint'(m_pr));
        chk($sformatf("d%0d.pass_down", i), longint'(pd_a[i]), longint'(m_pd));
      end
    end
  end

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic drive(bit s, int k, bit v, int a, int b);
    start = s; k_len = 8'(k); in_valid = v; in_a = 8'(a); in_b = 8'(b);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    idle(); idle();
    chk("reset.result", longint'(res_a[0]), 0);
    chk("reset.pass_valid", longint'(pv_a[0]), 0);
    chk("reset.busy", longint'(busy_a[0]), 0);
    chk("reset.result_valid", longint'(rv_a[0]), 0);
    rst = 1'b0;
    idle();

    // Basic tile: 2*3 + 4*5 + 1*1.
    drive(1'b1, 3, 1'b0, 0, 0);
    drive(1'b0, 0, 1'b1, 2, 3);
    drive(1'b0, 0, 1'b1, 4, 5);
    drive(1'b0, 0, 1'b1, 1, 1);
    chk("t1.result", longint'(res_a[0]), 27);
    chk("t1.result_valid", longint'(rv_a[0]), 1);
    chk("t1.busy", longint'(busy_a[0]), 0);
    idle();
    chk("t1.rv_once", longint'(rv_a[0]), 0);

    // 4 x 127*127 = 64516: clamps, wraps, or fits depending on configuration.
    drive(1'b1, 4, 1'b0, 0, 0);
    repeat (4) drive(1'b0, 0, 1'b1, 127, 127);
    chk("t2.sat.result", longint'(res_a[1]), 32767);
    chk("t2.sat.overflow", longint'(ovf_a[1]), 1);
    chk("t2.wrap.result", longint'(res_a[2]), 64516);
    chk("t2.wrap.overflow", longint'(ovf_a[2]), 1);
    chk("t2.wide.result", longint'(res_a[0]), 64516);
    chk("t2.wide.overflow", longint'(ovf_a[0]), 0);
    chk("t2.unsigned.result", longint'(res_a[3]), 64516);
    idle();

    // Gaps and pass-through hold.
    drive(1'b1, 2, 1'b0, 0, 0);
    drive(1'b0, 0, 1'b1, -3, 7);
    chk("t3.pass_right", longint'(pr_a[0]), 253);
    chk("t3.pass_down", longint'(pd_a[0]), 7);
    chk("t3.pass_valid", longint'(pv_a[0]), 1);
    idle();
    chk("t3.gap.pass_valid", longint'(pv_a[0]), 0);
    chk("t3.gap.pass_right", longint'(pr_a[0]), 253);
    idle();
    drive(1'b0, 0, 1'b1, 5, 5);
    chk("t3.result", longint'(res_a[0]), 4);
    chk("t3.result_valid", longint'(rv_a[0]), 1);
    idle();

    // Coincident start+beat, then back-to-back tile started in DONE.
    drive(1'b1, 1, 1'b1, 6, 6);
    chk("t4.a.result", longint'(res_a[0]), 36);
    chk("t4.a.result_valid", longint'(rv_a[0]), 1);
    drive(1'b1, 1, 1'b1, 2, 2);
    chk("t4.b.result", longint'(res_a[0]), 4);
    chk("t4.b.result_valid", longint'(rv_a[0]), 1);
    idle();
    chk("t4.hold.result", longint'(res_a[0]), 4);
    chk("t4.hold.result_valid", longint'(rv_a[0]), 0);

    // Restart mid-tile.
    drive(1'b1, 5, 1'b0, 0, 0);
    drive(1'b0, 0, 1'b1, 1, 2);
    drive(1'b0, 0, 1'b1, 3, 3);
    chk("t5.mid.busy", longint'(busy_a[0]), 1);
    drive(1'b1, 1, 1'b1, 1, 1);
    chk("t5.result", longint'(res_a[0]), 1);
    chk("t5.result_valid", longint'(rv_a[0]), 1);
    idle();

    // Reset mid-tile.
    drive(1'b1, 5, 1'b0, 0, 0);
    drive(1'b0, 0, 1'b1, 4, 4);
    drive(1'b0, 0, 1'b1, 4, 4);
    rst = 1'b1;
    idle();
    chk("t5.rst.result", longint'(res_a[0]), 0);
    chk("t5.rst.busy", longint'(busy_a[0]), 0);
    chk("t5.rst.pass_right", longint'(pr_a[0]), 0);
    rst = 1'b0;
    idle();
    chk("t5.rst.no_rv", longint'(rv_a[0]), 0);

    // Zero-length tile, then an operand seen while idle.
    drive(1'b1, 0, 1'b0, 0, 0);
    chk("t6.k0.result_valid", longint'(rv_a[0]), 1);
    chk("t6.k0.result", longint'(res_a[0]), 0);
    drive(1'b0, 0, 1'b1, 9, 9);
    chk("t6.idle.pass_right", longint'(pr_a[0]), 9);
    chk("t6.idle.result", longint'(res_a[0]), 0);
    chk("t6.idle.busy", longint'(busy_a[0]), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit s, v;
      int k;
      rst = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 11) == 0);
      k = $urandom_range(0, 6);
      v = ($urandom_range(0, 9) < 7);
      if (s && k == 0) v = 1'b0;
      drive(s, k, v, $urandom_range(0, 255), $urandom_range(0, 255));
    end
    rst = 1'b0;
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_pe_param.md
Name: systolic_pe_param

Overview:
Parametrised successor to the 8-bit systolic processing element. One MAC cell of an output-stationary systolic array.
- Forwards operand A right and operand B down with a valid tag.
- Accumulates exactly K products per output tile into a wide, optionally saturating accumulator, under a small tile-control FSM.
- Pulses result_valid when the tile completes.
- Instantiated N×N by the array wrapper; start is broadcast per tile.

Parameters:
- DATA_W, 8, operand width in bits.
- ACC_W, 24, accumulator/result width; must be ≥ 2*DATA_W.
- K_W, 8, width of the tile-length field (K up to 2^K_W−1).
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin new tile, latch k_len, clear accumulator.
- k_len  in  K_W  products in this tile; sampled only when start=1.
- in_valid  in  1  in_a/in_b carry a valid operand pair this cycle.
- in_a  in  DATA_W  row operand (from left neighbour).
- in_b  in  DATA_W  column operand (from upper neighbour).
- pass_valid  out  1  registered in_valid for both neighbours.
- pass_right  out  DATA_W  registered in_a.
- pass_down  out  DATA_W  registered in_b.
- busy  out  1  high in ACCUM state.
- result  out  ACC_W  accumulator value.
- result_valid  out  1  one-cycle pulse: tile complete, result final.
- overflow  out  1  sticky: saturation/wrap occurred in current tile.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs become 0.
  - FSM goes to IDLE; count = 0.
  - Reset mid-tile abandons the tile; no result_valid is issued.
- Pass-through registers, 1-cycle latency, independent of FSM state:
  - pass_valid <= in_valid.
  - pass_right and pass_down load in_a and in_b only when in_valid=1; otherwise they hold.
- Product:
  - Full 2*DATA_W product of in_a and in_b, signed or unsigned per SIGNED.
  - Sign- or zero-extended to ACC_W+1 bits; added to result.
- Overflow detection:
  - SIGNED: sum exceeds 2^(ACC_W−1)−1 or is below −2^(ACC_W−1). SATURATE=1 clamps to max/min.
  - Unsigned: carry out. SATURATE=1 clamps to 2^ACC_W−1.
  - SATURATE=0 keeps the low ACC_W bits.
  - Either way, overflow is set and stays set until the next start or rst.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE:
    - start with k_len=0 → DONE, result=0.
    - start with k_len>0 → ACCUM: result=0, overflow=0, count=0, K=k_len.
    - in_valid alone: forwarded, not accumulated.
  - ACCUM (busy=1):
    - Each in_valid beat: result <= sat(result+product), count += 1.
    - When the accumulated beat makes count == K → DONE.
    - Cycles without in_valid: hold.
  - DONE:
    - result_valid=1 for exactly this one cycle.
    - Next state is IDLE, unless start=1 (see below).
    - result holds its value until the next start.
- Start coincident with in_valid (from IDLE or DONE):
  - Clear and first accumulate happen together: result <= sat(product), count=1.
  - If K=1 → DONE next cycle; otherwise → ACCUM.
- start while in ACCUM:
  - Current tile is abandoned with no result_valid.
  - Treated as a fresh start, including the coincident-beat rule.
- start in DONE:
  - result_valid still pulses this cycle.
  - The new tile begins on the same edge, so back-to-back tiles have no bubble.
- result_valid and busy are never high in the same cycle.

Decomposition:
- Package systolic_pkg:
  - pe_state_t enum {IDLE, ACCUM, DONE}.
  - Functions acc_max(ACC_W,SIGNED) and acc_min(ACC_W,SIGNED).
  - Constant PE_LAT = 1 (pass-through latency), used by the array wrapper for skew.
- Sub-module pe_mac_datapath:
  - Combinational multiply, extend and saturating add.
  - Ports: a, b, acc_in, clr → sum, ovf.
  - Parametrised on DATA_W, ACC_W, SIGNED, SATURATE.
- FSM, counter and registers live in the top module.

Test Plan:
1. Basic tile, defaults:
   - start, k_len=3; beats (2,3), (4,5), (1,1) on consecutive cycles.
   - result = 27; result_valid pulses exactly once, 1 cycle after the 3rd beat; busy low that cycle.
2. Signed saturation:
   - ACC_W=16; start, k_len=4; in_a=127, in_b=127 ×4 (sums 16129, 32258, then clamp).
   - result = 32767; overflow = 1. Repeat with SATURATE=0: result = 64516 mod 65536 read as signed = −1020.
3. Gaps and pass-through:
   - k_len=2; beats (−3,7), two idle cycles, then (5,5).
   - result = 4; pass_right/pass_down show −3/7 one cycle after the first beat and hold through the gap; pass_valid mirrors in_valid delayed by 1.
4. Start with coincident beat, and back-to-back tiles:
   - start+in_valid (6,6), k_len=1 → result 36, result_valid next cycle.
   - start in that DONE cycle with beat (2,2) → second tile result 4; no idle cycle between tiles.
5. Mid-tile disruption:
   - k_len=5; after 2 beats, assert start (k_len=1, beat (1,1)) → result 1; only one result_valid, for the new tile.
   - Separately: rst after 2 beats → all outputs 0, FSM in IDLE, no result_valid.
6. Edge cases:
   - k_len=0 start → result 0, result_valid 1 cycle later.
   - in_valid in IDLE with (9,9) → forwarded to pass outputs; result stays 0.
